// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//   Refills one 4-word cache line from memory after a miss. Words are fetched
//   critical-word-first with wrap-around; each returned word is written into
//   the data array through the fill_* strobe, and fill_done pulses once the
//   whole line is in place.
//
//   Optional feature: define REFILL_TIMEOUT_EN to abort a refill that sits in
//   REQ or WAIT for TIMEOUT_CYCLES cycles. The abort sets the sticky
//   refill_error flag. Without the macro there is no counter, refill_error is
//   tied low and the controller waits indefinitely.
//
// Ports
//   clock         single clock, all logic on posedge
//   reset         synchronous active-low reset
//   miss_valid    miss awaiting refill
//   miss_address  missed line address (tag = miss_address[27:0])
//   miss_word     critical word index within the line
//   miss_ready    high in IDLE, when a miss can be accepted
//   mem_req       memory read request, held until mem_ack
//   mem_addr      word address {miss_address[29:0], beat_word}, 0 when idle
//   mem_ack       memory accepted mem_req
//   mem_rvalid    read data valid (honoured only in WAIT)
//   mem_rdata     read data
//   fill_valid    one-cycle write strobe into the data array
//   fill_tag      tag of the line being filled
//   fill_word     word index being written
//   fill_data     word being written
//   fill_done     one-cycle pulse, line complete
//   refill_error  sticky timeout flag (always 0 without REFILL_TIMEOUT_EN)
module cache_refill_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        miss_valid,
  input  logic [31:0] miss_address,
  input  logic [1:0]  miss_word,
  output logic        miss_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        fill_valid,
  output logic [27:0] fill_tag,
  output logic [1:0]  fill_word,
  output logic [63:0] fill_data,
  output logic        fill_done,
  output logic        refill_error
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    COMMIT
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [29:0] line_addr;
  logic [1:0]  crit_word;
  logic [1:0]  beat;
  logic [1:0]  beat_word;
  logic        accept;
  logic        beat_done;
  logic        tmo_fire;

  // The two top address bits never reach the word address.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^miss_address[31:30];

  assign accept    = (state == IDLE) && miss_valid;
  assign beat_done = (state == WAIT) && mem_rvalid;
  // 2-bit add wraps naturally: critical word first, then the rest of the line.
  assign beat_word = crit_word + beat;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a beat that completes in the same cycle the timeout
  // expires counts as progress and wins over the abort.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (miss_valid) state_nxt = REQ;
      end
      REQ: begin
        if (mem_ack)       state_nxt = WAIT;
        else if (tmo_fire) state_nxt = IDLE;
      end
      WAIT: begin
        if (mem_rvalid)    state_nxt = (beat == 2'd3) ? COMMIT : REQ;
        else if (tmo_fire) state_nxt = IDLE;
      end
      COMMIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    miss_ready = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        miss_ready = 1'b1;
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = {line_addr, beat_word};
      end
      COMMIT: begin
        fill_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Miss capture, beat counter and registered fill port
  always_ff @(posedge clock) begin
    if (!reset) begin
      line_addr  <= '0;
      crit_word  <= '0;
      beat       <= '0;
      fill_valid <= 1'b0;
      fill_tag   <= '0;
      fill_word  <= '0;
      fill_data  <= '0;
    end else begin
      fill_valid <= beat_done;
      if (accept) begin
        line_addr <= miss_address[29:0];
        crit_word <= miss_word;
        beat      <= '0;
      end
      if (beat_done) begin
        fill_tag  <= line_addr[27:0];
        fill_word <= beat_word;
        fill_data <= mem_rdata;
        beat      <= beat + 2'd1;
      end
    end
  end

`ifdef REFILL_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt;
  logic       err_q;

  // tmo_cnt holds the number of cycles already spent in the current
  // REQ/WAIT visit, so the abort lands on the TIMEOUT_CYCLES-th cycle.
  assign tmo_fire = (((state == REQ) && !mem_ack) ||
                     ((state == WAIT) && !mem_rvalid)) &&
                    (tmo_cnt == TMO_LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state_nxt != state) || !((state == REQ) || (state == WAIT))) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if (tmo_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign refill_error = err_q;
`else
  localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;

  assign tmo_fire     = 1'b0;
  assign refill_error = 1'b0;
`endif

endmodule
